// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_pkg
//  Purpose  : Shared AXI4-lite definitions for the NPC write master/slave
//             pair: default bus widths, response codes, slave FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  // Default bus widths, shared with the core-side write master.
  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;

  // Write response codes carried on B_RESP.
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Write-slave state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage : axi4_lite_pkg
`default_nettype wire

// File: rtl/axi4_lite_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_hold_reg
//  Purpose  : One-entry valid/ready capture register. Accepts a payload on a
//             VALID & READY handshake, holds it with a full flag until the
//             clear input drops the flag.
//  Ports    : clk, rst     - clock, asynchronous active-high reset
//             en_i         - acceptance allowed (registered state only)
//             valid_i      - upstream payload valid
//             ready_o      - upstream accept (en_i & ~full)
//             data_i       - upstream payload
//             clr_i        - drop the full flag
//             full_o       - entry holds a payload
//             data_o       - held payload
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_hold_reg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready_o = en_i & ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (valid_i && ready_o) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule : axi4_lite_hold_reg
`default_nettype wire

// File: rtl/axi4_lite_write_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_write_slave
//  Purpose  : AXI4-lite write responder for the NPC memory side. Collects an
//             AW and a W beat in any order, decodes the held address, issues
//             one byte-strobed memory write on OKAY, then returns B.
//  Ports    : clk, rst                       - clock, async active-high reset
//             AW_ADDR/AW_VALID/AW_PROT/AW_READY - write address channel
//             W_DATA/W_STRB/W_VALID/W_READY     - write data channel
//             B_RESP/B_VALID/B_READY            - write response channel
//             mem_wen/mem_waddr/mem_wdata/mem_wstrb - single-cycle write port
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_write_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned        ADDR_W     = AXI_ADDR_W,
  parameter int unsigned        DATA_W     = AXI_DATA_W,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(64'h8000_0000),
  parameter logic [ADDR_W-1:0]  SIZE_BYTES = ADDR_W'(64'h0800_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     AW_ADDR,
  input  logic                  AW_VALID,
  input  logic [2:0]            AW_PROT,
  output logic                  AW_READY,
  input  logic [DATA_W-1:0]     W_DATA,
  input  logic [DATA_W/8-1:0]   W_STRB,
  input  logic                  W_VALID,
  output logic                  W_READY,
  output logic [1:0]            B_RESP,
  output logic                  B_VALID,
  input  logic                  B_READY,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WBUS_W = DATA_W + STRB_W;

  // Window bounds widened by one bit so BASE+SIZE never wraps.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

  state_e              state_q, state_d;
  resp_t               resp_q, resp_d;
  resp_t               resp_dec;
  logic                flags_clr;
  logic                accept_en;
  logic                aw_full, w_full;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [WBUS_W-1:0]   w_bus_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                aw_full_next, w_full_next;
  logic                in_write;
  logic [ADDR_W:0]     addr_ext;
  logic                w_unused_prot;

  // Protection bits carry no meaning for this memory.
  assign w_unused_prot = ^AW_PROT;

  // Readies come from registered state; reset holds them low until release.
  assign accept_en = (state_q == ST_IDLE) & ~rst;

  axi4_lite_hold_reg #(
    .WIDTH (ADDR_W)
  ) u_aw_hold (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept_en),
    .valid_i (AW_VALID),
    .ready_o (AW_READY),
    .data_i  (AW_ADDR),
    .clr_i   (flags_clr),
    .full_o  (aw_full),
    .data_o  (aw_addr_q)
  );

  axi4_lite_hold_reg #(
    .WIDTH (WBUS_W)
  ) u_w_hold (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept_en),
    .valid_i (W_VALID),
    .ready_o (W_READY),
    .data_i  ({W_STRB, W_DATA}),
    .clr_i   (flags_clr),
    .full_o  (w_full),
    .data_o  (w_bus_q)
  );

  assign w_data_q = w_bus_q[DATA_W-1:0];
  assign w_strb_q = w_bus_q[WBUS_W-1:DATA_W];

  // Flag values after the coming edge, including a handshake on that edge.
  assign aw_full_next = aw_full | (AW_VALID & AW_READY);
  assign w_full_next  = w_full  | (W_VALID  & W_READY);

  // Address decode from the held address only.
  assign addr_ext = {1'b0, aw_addr_q};

  always_comb begin
    resp_dec = RESP_OKAY;
    if ((addr_ext < WIN_LO) || (addr_ext >= WIN_HI)) begin
      resp_dec = RESP_DECERR;
    end else if (aw_addr_q[2:0] != 3'b000) begin
      resp_dec = RESP_SLVERR;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    flags_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_full_next && w_full_next) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        resp_d  = resp_dec;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (B_READY) begin
          state_d   = ST_IDLE;
          flags_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory port shows the held beat only during the single WRITE cycle.
  assign in_write  = (state_q == ST_WRITE);
  assign mem_wen   = in_write && (resp_dec == RESP_OKAY);
  assign mem_waddr = in_write ? aw_addr_q : '0;
  assign mem_wdata = in_write ? w_data_q  : '0;
  assign mem_wstrb = in_write ? w_strb_q  : '0;

  assign B_VALID = (state_q == ST_RESP);
  assign B_RESP  = B_VALID ? resp_q : RESP_OKAY;

endmodule : axi4_lite_write_slave
`default_nettype wire

// File: tb/tb_axi4_lite_write_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_write_slave
//  Purpose  : Self-checking bench for axi4_lite_write_slave. Expected memory
//             writes and B responses are queued when stimulus is driven and
//             compared when the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_write_slave;
  import axi4_lite_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] LIMIT = 64'h8800_0000;
  localparam int          BOUND = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] AW_ADDR;
  logic        AW_VALID;
  logic [2:0]  AW_PROT;
  logic        AW_READY;
  logic [63:0] W_DATA;
  logic [7:0]  W_STRB;
  logic        W_VALID;
  logic        W_READY;
  logic [1:0]  B_RESP;
  logic        B_VALID;
  logic        B_READY;
  logic        mem_wen;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  always #5 clk = ~clk;

  axi4_lite_write_slave dut (
    .clk       (clk),
    .rst       (rst),
    .AW_ADDR   (AW_ADDR),
    .AW_VALID  (AW_VALID),
    .AW_PROT   (AW_PROT),
    .AW_READY  (AW_READY),
    .W_DATA    (W_DATA),
    .W_STRB    (W_STRB),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .B_RESP    (B_RESP),
    .B_VALID   (B_VALID),
    .B_READY   (B_READY),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } mexp_t;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_wen  = 0;
  int          n_okay = 0;
  mexp_t       mq[$];
  logic [1:0]  bq[$];
  mexp_t       mon_e;
  logic [63:0] mdl_img[logic [63:0]];
  logic [63:0] dut_img[logic [63:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [63:0] a);
    if (a < BASE || a >= LIMIT) return 2'b11;
    if (a[2:0] != 3'b000)       return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic push_exp(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [1:0]  r;
    logic [63:0] old;
    r = model_resp(a);
    bq.push_back(r);
    if (r == 2'b00) begin
      n_okay++;
      mq.push_back('{addr: a, data: d, strb: s});
      old = mdl_img.exists(a) ? mdl_img[a] : 64'd0;
      mdl_img[a] = merge(old, d, s);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wen) begin
        n_wen++;
        if (mq.size() == 0) begin
          check("mem_unexpected", 64'(mem_wen), 64'd0);
        end else begin
          mon_e = mq.pop_front();
          check("mem_waddr", mem_waddr, mon_e.addr);
          check("mem_wdata", mem_wdata, mon_e.data);
          check("mem_wstrb", 64'(mem_wstrb), 64'(mon_e.strb));
          dut_img[mem_waddr] = merge(dut_img.exists(mem_waddr) ? dut_img[mem_waddr] : 64'd0,
                                     mem_wdata, mem_wstrb);
        end
      end
      if (B_VALID && B_READY) begin
        if (bq.size() == 0) check("b_unexpected", 64'(B_VALID), 64'd0);
        else                check("b_resp", 64'(B_RESP), 64'(bq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [63:0] a, input int dly);
    int t = 0;
    repeat (dly) tick();
    AW_ADDR  = a;
    AW_VALID = 1'b1;
    while (!AW_READY && t < BOUND) begin tick(); t++; end
    if (!AW_READY) begin
      check("aw_timeout", 64'(AW_READY), 64'd1);
      AW_VALID = 1'b0;
      return;
    end
    tick();
    AW_VALID = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input int dly);
    int t = 0;
    repeat (dly) tick();
    W_DATA  = d;
    W_STRB  = s;
    W_VALID = 1'b1;
    while (!W_READY && t < BOUND) begin tick(); t++; end
    if (!W_READY) begin
      check("w_timeout", 64'(W_READY), 64'd1);
      W_VALID = 1'b0;
      return;
    end
    tick();
    W_VALID = 1'b0;
  endtask

  // Wait for B, optionally stall B_READY for 'gap' cycles while offering a
  // second AW/W beat that must not be taken.
  task automatic wait_b(input int gap, input bit offer);
    int         t = 0;
    logic [1:0] r0;
    B_READY = (gap == 0);
    while (!B_VALID && t < BOUND) begin tick(); t++; end
    if (!B_VALID) begin
      check("b_timeout", 64'(B_VALID), 64'd1);
      B_READY = 1'b0;
      return;
    end
    r0 = B_RESP;
    if (offer) begin
      AW_ADDR  = BASE + 64'h100;
      AW_VALID = 1'b1;
      W_VALID  = 1'b1;
    end
    for (int i = 0; i < gap; i++) begin
      check("hold_b_valid", 64'(B_VALID), 64'd1);
      check("hold_b_resp", 64'(B_RESP), 64'(r0));
      check("hold_aw_ready", 64'(AW_READY), 64'd0);
      check("hold_w_ready", 64'(W_READY), 64'd0);
      tick();
    end
    AW_VALID = 1'b0;
    W_VALID  = 1'b0;
    B_READY  = 1'b1;
    tick();
    B_READY  = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int awd, input int wd, input int gap);
    push_exp(a, d, s);
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    wait_b(gap, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    int          t;
    logic [63:0] a;

    AW_ADDR = '0; AW_VALID = 1'b0; AW_PROT = 3'b010;
    W_DATA  = '0; W_STRB   = '0;   W_VALID = 1'b0;
    B_READY = 1'b0;

    // Reset state.
    #1;
    check("rst_aw_ready", 64'(AW_READY), 64'd0);
    check("rst_w_ready", 64'(W_READY), 64'd0);
    check("rst_b_valid", 64'(B_VALID), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_b_resp", 64'(B_RESP), 64'd0);
    check("rst_mem_waddr", mem_waddr, 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rel_aw_ready", 64'(AW_READY), 64'd1);
    check("rel_w_ready", 64'(W_READY), 64'd1);

    // AW and W together, B_READY already high: exact latency.
    push_exp(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    AW_ADDR = 64'h8000_0010; AW_VALID = 1'b1;
    W_DATA  = 64'h1122_3344_5566_7788; W_STRB = 8'hFF; W_VALID = 1'b1;
    B_READY = 1'b1;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0;
    check("t1_wen_n1", 64'(mem_wen), 64'd1);
    check("t1_aw_ready_n1", 64'(AW_READY), 64'd0);
    tick();
    check("t1_b_valid_n2", 64'(B_VALID), 64'd1);
    check("t1_b_resp_n2", 64'(B_RESP), 64'd0);
    check("t1_wen_n2", 64'(mem_wen), 64'd0);
    tick();
    check("t1_aw_ready_n3", 64'(AW_READY), 64'd1);
    check("t1_w_ready_n3", 64'(W_READY), 64'd1);
    check("t1_b_valid_n3", 64'(B_VALID), 64'd0);
    B_READY = 1'b0;

    // W first, AW five cycles later.
    push_exp(64'h8000_0008, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F);
    W_DATA = 64'hCAFE_F00D_DEAD_BEEF; W_STRB = 8'h0F; W_VALID = 1'b1;
    tick();
    W_VALID = 1'b0;
    check("t2_w_ready_low", 64'(W_READY), 64'd0);
    check("t2_aw_ready_high", 64'(AW_READY), 64'd1);
    repeat (4) tick();
    check("t2_aw_ready_wait", 64'(AW_READY), 64'd1);
    check("t2_no_early_wen", 64'(mem_wen), 64'd0);
    AW_ADDR = 64'h8000_0008; AW_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0;
    check("t2_wen", 64'(mem_wen), 64'd1);
    wait_b(0, 1'b0);

    // Decode errors: no memory write expected.
    do_write(64'h7FFF_FFF8, 64'h1, 8'hFF, 0, 0, 0);
    do_write(64'h8800_0000, 64'h2, 8'hFF, 0, 0, 0);
    do_write(64'h8000_0004, 64'h3, 8'hFF, 0, 0, 0);
    // Zero strobe with OKAY still pulses mem_wen.
    do_write(64'h87FF_FFF8, 64'h4, 8'h00, 1, 0, 0);

    // B_READY stalled 10 cycles with a second beat offered.
    w0 = n_wen;
    push_exp(64'h8000_0020, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    fork
      send_aw(64'h8000_0020, 0);
      send_w(64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0);
    join
    wait_b(10, 1'b1);
    check("t4_wen_count", 64'(n_wen - w0), 64'd1);
    check("t4_aw_ready_after", 64'(AW_READY), 64'd1);

    // Asynchronous reset in RESP.
    push_exp(64'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'hF0);
    fork
      send_aw(64'h8000_0030, 0);
      send_w(64'h0123_4567_89AB_CDEF, 8'hF0, 2);
    join
    B_READY = 1'b0;
    t = 0;
    while (!B_VALID && t < BOUND) begin tick(); t++; end
    check("t5_in_resp", 64'(B_VALID), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_b_valid", 64'(B_VALID), 64'd0);
    check("t5_async_wen", 64'(mem_wen), 64'd0);
    bq.delete();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("t5_rel_aw_ready", 64'(AW_READY), 64'd1);
    check("t5_rel_w_ready", 64'(W_READY), 64'd1);
    B_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_no_stale_b", 64'(B_VALID), 64'd0);
    end
    B_READY = 1'b0;

    // Back-to-back random writes.
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 4)
        a = BASE + 64'(8 * $urandom_range(0, 31)) + 64'($urandom_range(1, 7));
      else if (i % 7 == 6)
        a = LIMIT + 64'(8 * $urandom_range(0, 31));
      else
        a = BASE + 64'(8 * $urandom_range(0, 31));
      do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (3) tick();

    check("mem_queue_left", 64'(mq.size()), 64'd0);
    check("b_queue_left", 64'(bq.size()), 64'd0);
    check("wen_total", 64'(n_wen), 64'(n_okay));
    foreach (mdl_img[k]) begin
      check("mem_image", dut_img.exists(k) ? dut_img[k] : 64'hDEAD_DEAD_DEAD_DEAD, mdl_img[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_axi4_lite_write_slave
`default_nettype wire
